ifu_fetch: RTL

//   Instruction fetch stage directly upstream of the control unit (cu).

---
 rtl/isa_pkg.sv | 39 +++
 rtl/instr_rom.sv | 19 +
 rtl/ifu_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch stage and its consumers: field layout, NOP,
// fetch FSM encodings and the field-split helper.
package isa_pkg;

  localparam int unsigned IW     = 16;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned OP_LSB = 9;
  localparam int unsigned RS_LSB = 6;
  localparam int unsigned RT_LSB = 3;
  localparam int unsigned RD_LSB = 0;

  localparam logic [IW-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op_code;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } instr_fields_t;

  // Split a 16-bit instruction word into its opcode and register fields.
  function automatic instr_fields_t split_instr(input logic [IW-1:0] w);
    instr_fields_t f;
    f.op_code = w[OP_LSB +: OP_W];
    f.rs      = w[RS_LSB +: REG_W];
    f.rt      = w[RT_LSB +: REG_W];
    f.rd      = w[RD_LSB +: REG_W];
    return f;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Program ROM with an asynchronous read port; contents fixed at elaboration from
// a packed image (word i at bits [i*IW +: IW]). Addresses past DEPTH read as NOP.
module instr_rom
  import isa_pkg::*;
#(
  parameter int unsigned       AW    = 8,
  parameter int unsigned       DEPTH = 256,
  parameter logic [DEPTH*IW-1:0] IMAGE = '0
) (
  input  logic [AW-1:0] addr_i,
  output logic [IW-1:0] rdata_c
);

  logic [31:0] addr_ext;

  assign addr_ext = 32'(addr_i);
  assign rdata_c  = (addr_ext < DEPTH) ? IMAGE[addr_ext*IW +: IW] : NOP;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, instruction register and fetch FSM feeding the cu
// and register file through a valid/ready handshake.
module ifu_fetch
  import isa_pkg::*;
#(
  parameter int unsigned         AW        = 8,
  parameter int unsigned         DEPTH     = 256,
  parameter logic [DEPTH*IW-1:0] ROM_IMAGE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  input  logic              jmp_en,
  input  logic [AW-1:0]     jmp_addr,
  output logic              valid,
  output logic [IW-1:0]     instr,
  output logic [OP_W-1:0]   op_code,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  rd,
  output logic [AW-1:0]     pc,
  output logic              halted
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic [IW-1:0] rom_data_c;
  instr_fields_t fields;

  instr_rom #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .IMAGE (ROM_IMAGE)
  ) u_rom (
    .addr_i  (pc_q),
    .rdata_c (rom_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: a jump beats a fetch; a fetch happens whenever the IR is empty or draining.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end

      ST_RUN: begin
        if (jmp_en) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
          instr_d = NOP;
        end else if (!valid_q || ready) begin
          instr_d = rom_data_c;
          valid_d = 1'b1;
          if (pc_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (jmp_en) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
          instr_d = NOP;
          state_d = ST_RUN;
        end else if (valid_q && ready) begin
          valid_d  = 1'b0;
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      end

      ST_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        if (start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        pc_d     = '0;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  assign fields  = split_instr(instr_q);
  assign valid   = valid_q;
  assign instr   = instr_q;
  assign op_code = fields.op_code;
  assign rs      = fields.rs;
  assign rt      = fields.rt;
  assign rd      = fields.rd;
  assign pc      = pc_q;
  assign halted  = halted_q;

endmodule
